// File: rtl/f_pc_ras_unit.sv
// Fetch PC register with folded next-PC select, delay-slot flag and a circular return-address stack.
// Optional macro F_ADEL_CHECK_EN builds the F-stage address-error check; otherwise f_exc_adel is tied low.
module f_pc_ras_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC     = 32'h0000_4180,
  parameter logic [31:0] ERET_OFFSET = 32'd0,
  parameter int          RAS_DEPTH   = 4,
  parameter int          RAS_AW      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] d_pc,
  input  logic [2:0]  npc_op,
  input  logic        b_jump,
  input  logic [31:0] ra,
  input  logic [25:0] imm,
  input  logic        d_link31,
  input  logic        d_ret31,
  output logic [31:0] f_pc,
  output logic [31:0] npc,
  output logic        f_bd,
  output logic [31:0] ras_top,
  output logic        ras_empty,
  output logic        ras_miss,
  output logic [15:0] ras_miss_cnt,
  output logic        f_exc_adel
);

  localparam logic [RAS_AW:0] CNT_FULL = (RAS_AW+1)'(RAS_DEPTH);

  logic signed [31:0] br_off;
  logic [31:0]        ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0]  ras_ptr;
  logic [RAS_AW-1:0]  top_idx;
  logic [RAS_AW-1:0]  wr_idx;
  logic [RAS_AW:0]    ras_cnt;
  logic               ras_upd;
  logic               miss_p0;
  logic               miss_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [RAS_AW:0] sat_inc_cnt(input logic [RAS_AW:0] v);
    return (v == CNT_FULL) ? v : v + (RAS_AW+1)'(1);
  endfunction

  // Stage p0: next-PC select and RAS lookup
  assign br_off = signed'({{14{imm[15]}}, imm[15:0], 2'b00});

  always_comb begin
    npc = f_pc + 32'd4;
    if (req) begin
      npc = EXC_VEC;
    end else if (eret) begin
      npc = epc + ERET_OFFSET;
    end else begin
      case (npc_op)
        3'd1:    if (b_jump) npc = d_pc + 32'd4 + $unsigned(br_off);
        3'd2:    npc = {d_pc[31:28], imm, 2'b00};
        3'd3:    npc = ra;
        default: npc = f_pc + 32'd4;
      endcase
    end
  end

  assign top_idx   = ras_ptr - RAS_AW'(1);
  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_empty ? 32'd0 : ras_mem[top_idx];
  assign ras_upd   = !reset && !req && !eret && !stall;
  assign miss_p0   = ras_upd && d_ret31 && (ras_empty || (ra != ras_top));
  // A simultaneous link+return replaces the top in place rather than moving the pointer.
  assign wr_idx    = d_ret31 ? top_idx : ras_ptr;

  // Stage p1: PC, delay-slot flag and RAS state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc <= RESET_PC;
      f_bd <= 1'b0;
    end else if (req || eret) begin
      f_pc <= npc;
      f_bd <= 1'b0;
    end else if (!stall) begin
      f_pc <= npc;
      f_bd <= (npc_op == 3'd1) || (npc_op == 3'd2) || (npc_op == 3'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr      <= '0;
      ras_cnt      <= '0;
      miss_p1      <= 1'b0;
      ras_miss_cnt <= 16'd0;
    end else begin
      miss_p1 <= miss_p0;
      if (miss_p0) ras_miss_cnt <= sat_inc16(ras_miss_cnt);
      if (ras_upd) begin
        if (d_link31 && d_ret31) begin
          if (ras_empty) ras_cnt <= (RAS_AW+1)'(1);
        end else if (d_link31) begin
          ras_ptr <= ras_ptr + RAS_AW'(1);
          ras_cnt <= sat_inc_cnt(ras_cnt);
        end else if (d_ret31 && !ras_empty) begin
          ras_ptr <= top_idx;
          ras_cnt <= ras_cnt - (RAS_AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ras_upd && d_link31) ras_mem[wr_idx] <= d_pc + 32'd8;
  end

  assign ras_miss = miss_p1;

`ifdef F_ADEL_CHECK_EN
  assign f_exc_adel = (f_pc[1:0] != 2'b00) || (f_pc < 32'h0000_3000) || (f_pc > 32'h0000_6FFF);
`else
  assign f_exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_ras_unit.sv
// Directed scoreboard bench for f_pc_ras_unit: PC select, delay-slot flag, exception/eret and RAS behaviour.
module tb_f_pc_ras_unit;
  logic        clk = 1'b0;
  logic        reset, stall, req, eret, b_jump, d_link31, d_ret31;
  logic [31:0] epc, d_pc, ra;
  logic [2:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] f_pc, npc, ras_top;
  logic        f_bd, ras_empty, ras_miss, f_exc_adel;
  logic [15:0] ras_miss_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef enum int {F_PC, F_BD, R_TOP, R_EMPTY, R_MISS, R_CNT, F_ADEL, F_NPC} fld_t;
  typedef struct {
    string       tag;
    fld_t        fld;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

`ifdef F_ADEL_CHECK_EN
  localparam logic ADEL_ON = 1'b1;
`else
  localparam logic ADEL_ON = 1'b0;
`endif

  f_pc_ras_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
    .d_pc(d_pc), .npc_op(npc_op), .b_jump(b_jump), .ra(ra), .imm(imm),
    .d_link31(d_link31), .d_ret31(d_ret31), .f_pc(f_pc), .npc(npc), .f_bd(f_bd),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_miss(ras_miss),
    .ras_miss_cnt(ras_miss_cnt), .f_exc_adel(f_exc_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_obs(input fld_t f);
    case (f)
      F_PC:    return f_pc;
      F_BD:    return {31'd0, f_bd};
      R_TOP:   return ras_top;
      R_EMPTY: return {31'd0, ras_empty};
      R_MISS:  return {31'd0, ras_miss};
      R_CNT:   return {16'd0, ras_miss_cnt};
      F_ADEL:  return {31'd0, f_exc_adel};
      default: return npc;
    endcase
  endfunction

  task automatic expect_v(input string tag, input fld_t f, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.fld = f; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = get_obs(e.fld);
      cmp_cnt++;
      assert (obs === e.exp) else begin
        err_cnt++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; req = 0; eret = 0; npc_op = 3'd0; b_jump = 0;
    d_link31 = 0; d_ret31 = 0;
  endtask

  task automatic ras_chk(input string tag, input logic [31:0] top, input logic emp,
                         input logic miss, input logic [15:0] cnt);
    expect_v({tag, "_top"},   R_TOP,   top);
    expect_v({tag, "_empty"}, R_EMPTY, {31'd0, emp});
    expect_v({tag, "_miss"},  R_MISS,  {31'd0, miss});
    expect_v({tag, "_cnt"},   R_CNT,   {16'd0, cnt});
  endtask

  initial begin
    idle(); reset = 1; epc = 0; d_pc = 0; ra = 0; imm = 0;
    step(); step();
    expect_v("rst_pc", F_PC, 32'h3000); expect_v("rst_bd", F_BD, 0);
    expect_v("rst_adel", F_ADEL, 0);
    ras_chk("rst", 32'd0, 1, 0, 0);
    check_all();

    // sequential fetch
    reset = 0; #1;
    expect_v("npc_pc4", F_NPC, 32'h3004); check_all();
    expect_v("seq_pc1", F_PC, 32'h3004); step();
    expect_v("seq_pc2", F_PC, 32'h3008); expect_v("seq_bd", F_BD, 0); step();

    // taken backward branch, then not taken
    d_pc = 32'h3010; npc_op = 3'd1; b_jump = 1; imm = 26'h000FFFC; #1;
    expect_v("npc_br_t", F_NPC, 32'h3004); check_all();
    expect_v("br_t_pc", F_PC, 32'h3004); expect_v("br_t_bd", F_BD, 1); step();
    b_jump = 0; #1;
    expect_v("npc_br_nt", F_NPC, 32'h3008); check_all();
    expect_v("br_nt_pc", F_PC, 32'h3008); expect_v("br_nt_bd", F_BD, 1); step();

    // j, jr, reserved op
    npc_op = 3'd2; imm = 26'h0000C04;
    expect_v("j_pc", F_PC, 32'h3010); expect_v("j_bd", F_BD, 1); step();
    npc_op = 3'd3; ra = 32'h3020;
    expect_v("jr_pc", F_PC, 32'h3020); step();
    npc_op = 3'd5;
    expect_v("op5_pc", F_PC, 32'h3024); expect_v("op5_bd", F_BD, 0); step();

    // stall holds PC and a set delay-slot flag
    npc_op = 3'd1; b_jump = 0;
    expect_v("pre_stall_bd", F_BD, 1); step();
    npc_op = 3'd0; stall = 1;
    expect_v("stall_pc", F_PC, 32'h3028); expect_v("stall_bd", F_BD, 1); step();

    // req overrides stall and eret; then eret
    req = 1; eret = 1; epc = 32'h3020; #1;
    expect_v("npc_req_prio", F_NPC, 32'h4180); check_all();
    eret = 0;
    expect_v("req_pc", F_PC, 32'h4180); expect_v("req_bd", F_BD, 0); step();
    req = 0; stall = 0; eret = 1; npc_op = 3'd1;
    expect_v("eret_pc", F_PC, 32'h3020); expect_v("eret_bd", F_BD, 0); step();
    idle();

    // five pushes overflow the 4-deep stack
    npc_op = 3'd0; d_link31 = 1;
    d_pc = 32'h3000; ras_chk("push0", 32'h3008, 0, 0, 0); step();
    d_pc = 32'h3100; expect_v("push1_top", R_TOP, 32'h3108); step();
    d_pc = 32'h3200; expect_v("push2_top", R_TOP, 32'h3208); step();
    d_pc = 32'h3300; expect_v("push3_top", R_TOP, 32'h3308); step();
    d_pc = 32'h3400; ras_chk("push4", 32'h3408, 0, 0, 0); step();
    d_link31 = 0; d_ret31 = 1;
    ra = 32'h3408; ras_chk("pop0", 32'h3308, 0, 0, 0); step();
    ra = 32'h3308; ras_chk("pop1", 32'h3208, 0, 0, 0); step();
    ra = 32'h3208; ras_chk("pop2", 32'h3108, 0, 0, 0); step();
    ra = 32'h3108; ras_chk("pop3", 32'h0, 1, 0, 0); step();
    ra = 32'h3008; ras_chk("pop_empty", 32'h0, 1, 1, 1); step();
    d_ret31 = 0; ras_chk("pop_empty_after", 32'h0, 1, 0, 1); step();

    // stalled push/pop leave the stack alone
    stall = 1; d_link31 = 1; d_pc = 32'h3500;
    ras_chk("stall_push", 32'h0, 1, 0, 1); step();
    d_link31 = 0; d_ret31 = 1; ra = 32'h1;
    ras_chk("stall_pop", 32'h0, 1, 0, 1); step();
    stall = 0; d_ret31 = 0; d_link31 = 1;
    ras_chk("push_3500", 32'h3508, 0, 0, 1); step();
    d_link31 = 0; d_ret31 = 1; ra = 32'h1234;
    ras_chk("pop_bad", 32'h0, 1, 1, 2); step();
    d_ret31 = 0; ras_chk("pop_bad_after", 32'h0, 1, 0, 2); step();

    // link and return in the same cycle
    d_link31 = 1; d_pc = 32'h3600;
    expect_v("push_3600_top", R_TOP, 32'h3608); step();
    d_ret31 = 1; d_pc = 32'h3700; ra = 32'h3608;
    ras_chk("swap_hit", 32'h3708, 0, 0, 2); step();
    d_link31 = 0; ra = 32'h3708;
    ras_chk("swap_pop", 32'h0, 1, 0, 2); step();
    d_link31 = 1; d_pc = 32'h3800; ra = 32'h3808;
    ras_chk("swap_empty", 32'h3808, 0, 1, 3); step();
    d_ret31 = 0; d_link31 = 0;
    ras_chk("swap_empty_after", 32'h3808, 0, 0, 3); step();

    // req with RAS traffic does not touch the stack
    req = 1; d_ret31 = 1; ra = 32'h0;
    ras_chk("req_hold", 32'h3808, 0, 0, 3); step();
    idle();

    // address-error check on jr targets
    npc_op = 3'd3; ra = 32'h3002;
    expect_v("adel_unal", F_ADEL, {31'd0, ADEL_ON}); step();
    ra = 32'h7000;
    expect_v("adel_hi", F_ADEL, {31'd0, ADEL_ON}); step();
    ra = 32'h3004;
    expect_v("adel_ok", F_ADEL, 0); expect_v("adel_ok_pc", F_PC, 32'h3004); step();
    idle();

    // reset mid-sequence clears everything
    reset = 1;
    expect_v("rst2_pc", F_PC, 32'h3000); ras_chk("rst2", 32'h0, 1, 0, 0); step();
    reset = 0; step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
